mem_subsys: RTL
===============

Name: mem_subsys

Overview:
- Parametrised next-generation memory subsystem for the single-cycle RV32I core.
- Contains:
  - a byte-addressable data RAM with RV32I sized loads and stores;
  - an instruction ROM;
  - an MMIO block with N_LED output registers, a synchronised key input, and a maskable, edge-triggered, write-1-to-clear interrupt controller.
- Sits between the core's load/store and fetch ports and the board I/O.

Parameters:
- ADDR_W, 16, byte-address width of both the data and instruction ports.
- DM_WORDS, 1024, data RAM depth in 32-bit words (power of 2).
- IM_WORDS, 1024, instruction ROM depth in 32-bit words (power of 2).
- IM_INIT, "program.hex", $readmemh file for the ROM.
- N_LED, 2, number of 32-bit LED output registers (1..8).
- MMIO_BASE, 16'hFF00, byte address of the MMIO window (64-byte aligned).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  store enable.
- funct3  in  3  RV32I load/store size code.
- addr_ram  in  ADDR_W  data byte address.
- data  in  32  store data (LSB-aligned).
- out_ram  out  32  load data, sign/zero-extended.
- addr_rom  in  ADDR_W  fetch byte address.
- out_rom  out  32  instruction word.
- key  in  32  asynchronous key/switch inputs.
- led  out  32*N_LED  LED registers; LED i occupies bits [32i+31:32i].
- irq  out  1  registered interrupt request.
- misalign  out  1  combinational flag for a misaligned access.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - led, IRQ_MASK, IRQ_PEND, key sync flops and irq all clear to 0.
  - RAM and ROM contents are not reset.
- Reads on both ports are combinational, with zero latency.
- Writes commit on the rising clk edge when we=1.
- Size decode:
  - 000 LB/SB
  - 001 LH/SH
  - 010 LW/SW
  - 100 LBU
  - 101 LHU
  - Stores use funct3[1:0] only.
  - Any other load code returns 0.
- Byte lanes: a byte access selects lane addr[1:0]; a halfword access selects lanes addr[1]*2..+1. Lanes not selected are unchanged on stores.
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Misaligned access: a halfword with addr[0]=1, or a word with addr[1:0]!=0.
  - misalign=1; the store is suppressed; the load returns 0.
- Address decode:
  - addr < DM_WORDS*4: RAM at word index addr[log2(DM_WORDS)+1:2].
  - MMIO_BASE <= addr < MMIO_BASE+64: MMIO.
  - Any other address reads 0 and ignores writes.
- MMIO is word-only. Sized accesses to MMIO are treated as word accesses at addr & ~3.
- MMIO map (offsets from MMIO_BASE):
  - 0x00 KEY: read-only, synchronised key value.
  - 0x04 IRQ_PEND: read; writing 1 clears a bit.
  - 0x08 IRQ_MASK: read/write.
  - 0x10+4i LED i: read/write, for i < N_LED.
  - Unmapped offsets read 0 and ignore writes.
- Key path:
  - Two-flop synchroniser s1 -> s2, plus history flop s3.
  - rise = s2 & ~s3 (per bit).
  - IRQ_PEND <= (IRQ_PEND & ~w1c) | rise.
  - If a W1C and a rise hit the same bit in the same cycle, the set wins.
- irq <= |(IRQ_PEND & IRQ_MASK), registered.
  - A key rising before edge 1 gives pend=1 after edge 3 and irq=1 after edge 4 (mask already set).
  - A mask write takes effect on irq one edge later.
- Held keys produce one pending set only. A falling edge does nothing.
- ROM: out_rom = rom[addr_rom[log2(IM_WORDS)+1:2]]. Out-of-range addresses return 32'h00000013 (NOP). addr_rom[1:0] is ignored.
- Reset asserted mid-operation: a store in the same cycle is discarded. MMIO registers clear immediately; RAM keeps its contents.

Test Plan:
- Reset, then read LED0 and IRQ_PEND -> both 0; led=0 and irq=0.
- SW 0x80FF7F01 @0x0010, then loads @0x0010:
  - LB@+0 -> 0x00000001; LB@+1 -> 0x0000007F; LB@+2 -> 0xFFFFFFFF; LBU@+3 -> 0x00000080;
  - LH@+2 -> 0xFFFF80FF; LHU@+2 -> 0x000080FF.
- SB 0xAA @0x0011 after the previous step -> LW@0x0010 = 0x80FFAA01.
- SH @0x0011 -> misalign=1 and RAM unchanged. LW@0x0012 -> 0 with misalign=1.
- Write IRQ_MASK=0x1, raise key[0] before edge 1:
  - IRQ_PEND=1 after edge 3; irq=1 after edge 4.
  - Write IRQ_PEND=0x1 -> pend 0, irq 0 one edge later.
  - Same-cycle rise and W1C on bit 0 -> pend remains 1.
- Write LED1=0xDEADBEEF -> led[63:32]=0xDEADBEEF and a read returns it.
  - Fetch @0x0FFC in range returns the ROM word; fetch @(IM_WORDS*4) returns 0x00000013.

Source files
------------

// File: rtl/mem_subsys.sv
// Memory subsystem for the single-cycle RV32I core.
// Holds the byte-addressable data RAM with RV32I sized loads and stores, the
// instruction ROM, and an MMIO block. The MMIO block provides the LED
// registers, a synchronised key input and an edge-triggered, maskable,
// write-1-to-clear interrupt controller.
//
// Access model: there is no handshake. Reads on both ports are combinational
// and have zero latency. A store commits on the rising edge of clk whenever
// we=1. A misaligned RAM access, an unmapped address or an invalid size code
// never changes any state.
module mem_subsys #(
    parameter int                ADDR_W    = 16,
    parameter int                DM_WORDS  = 1024,
    parameter int                IM_WORDS  = 1024,
    parameter                    IM_INIT   = "program.hex",
    parameter int                N_LED     = 2,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 16'hFF00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [2:0]            funct3,
    input  logic [ADDR_W-1:0]     addr_ram,
    input  logic [31:0]           data,
    output logic [31:0]           out_ram,
    input  logic [ADDR_W-1:0]     addr_rom,
    output logic [31:0]           out_rom,
    input  logic [31:0]           key,
    output logic [32*N_LED-1:0]   led,
    output logic                  irq,
    output logic                  misalign
);

    localparam int                DM_AW    = $clog2(DM_WORDS);
    localparam int                IM_AW    = $clog2(IM_WORDS);
    localparam logic [ADDR_W:0]   DM_BYTES = (ADDR_W+1)'(DM_WORDS * 4);
    localparam logic [ADDR_W:0]   IM_BYTES = (ADDR_W+1)'(IM_WORDS * 4);
    localparam logic [31:0]       NOP      = 32'h0000_0013;

    // Storage. The ROM powers up as all NOPs. The build flow replaces that
    // image with the program named by IM_INIT.
    logic [31:0] ram_q [DM_WORDS];
    logic [31:0] rom_q [IM_WORDS] = '{default: NOP};

    // MMIO state
    logic [31:0]             key_s1_q, key_s2_q, key_s3_q;
    logic [31:0]             pend_q, pend_d;
    logic [31:0]             mask_q, mask_d;
    logic [N_LED-1:0][31:0]  led_q, led_d;
    logic                    irq_q, irq_d;

    // Decode
    logic [1:0]        sz;
    logic              ram_hit, mmio_hit, mis_raw, size_ok, load_ok;
    logic              ram_we, mmio_we;
    logic [DM_AW-1:0]  ram_idx;
    logic [3:0]        mmio_off;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rword, ram_load, mmio_rdata, w1c, rise;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic              unused_bits;

    assign sz       = funct3[1:0];
    assign ram_hit  = ({1'b0, addr_ram} < DM_BYTES);
    assign mmio_hit = (addr_ram[ADDR_W-1:6] == MMIO_BASE[ADDR_W-1:6]);
    assign ram_idx  = addr_ram[DM_AW+1:2];
    assign mmio_off = addr_ram[5:2];
    assign size_ok  = (sz != 2'b11);
    assign load_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
    assign mis_raw  = ((sz == 2'b01) && addr_ram[0]) ||
                      ((sz == 2'b10) && (addr_ram[1:0] != 2'b00));
    // MMIO is word-only, so alignment is meaningless there
    assign misalign = mis_raw && !mmio_hit;
    assign ram_we   = we && ram_hit && !mis_raw && size_ok;
    assign mmio_we  = we && mmio_hit && size_ok;
    assign rise     = key_s2_q & ~key_s3_q;
    assign w1c      = (mmio_we && (mmio_off == 4'd1)) ? data : 32'h0;
    assign led      = led_q;
    assign irq      = irq_q;

    // The ROM image name and the byte offset of a fetch carry no logic
    assign unused_bits = ^{IM_INIT, addr_rom[1:0]};

    // Store lane enables and data replicated onto every lane
    always_comb begin
        be    = 4'b0000;
        wdata = data;
        case (sz)
            2'b00: begin
                be    = 4'b0001 << addr_ram[1:0];
                wdata = {4{data[7:0]}};
            end
            2'b01: begin
                be    = addr_ram[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data[15:0]}};
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // RAM write port. A store that coincides with reset is dropped.
    always_ff @(posedge clk) begin
        if (ram_we && rst_n) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram_q[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // RAM load path: select the lane, then sign- or zero-extend it
    always_comb begin
        rword = ram_q[ram_idx];
        case (addr_ram[1:0])
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        rhalf = addr_ram[1] ? rword[31:16] : rword[15:0];
        case (funct3)
            3'b000:  ram_load = {{24{rbyte[7]}}, rbyte};
            3'b001:  ram_load = {{16{rhalf[15]}}, rhalf};
            3'b010:  ram_load = rword;
            3'b100:  ram_load = {24'h0, rbyte};
            3'b101:  ram_load = {16'h0, rhalf};
            default: ram_load = 32'h0;
        endcase
    end

    // MMIO read mux; offsets that are not mapped read as zero
    always_comb begin
        mmio_rdata = 32'h0;
        case (mmio_off)
            4'd0:    mmio_rdata = key_s2_q;
            4'd1:    mmio_rdata = pend_q;
            4'd2:    mmio_rdata = mask_q;
            default: mmio_rdata = 32'h0;
        endcase
        for (int i = 0; i < N_LED; i++) begin
            if (mmio_off == 4'(4 + i)) mmio_rdata = led_q[i];
        end
    end

    // Load result: a misaligned or unmapped access returns zero
    always_comb begin
        out_ram = 32'h0;
        if (!misalign) begin
            if (ram_hit)                  out_ram = ram_load;
            else if (mmio_hit && load_ok) out_ram = mmio_rdata;
        end
    end

    // MMIO next state. A new rising key edge wins over a same-cycle clear.
    always_comb begin
        pend_d = (pend_q & ~w1c) | rise;
        mask_d = mask_q;
        led_d  = led_q;
        irq_d  = |(pend_q & mask_q);
        if (mmio_we && (mmio_off == 4'd2)) mask_d = data;
        for (int i = 0; i < N_LED; i++) begin
            if (mmio_we && (mmio_off == 4'(4 + i))) led_d[i] = data;
        end
    end

    // MMIO registers, key synchroniser and history flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q <= 32'h0;
            key_s2_q <= 32'h0;
            key_s3_q <= 32'h0;
            pend_q   <= 32'h0;
            mask_q   <= 32'h0;
            led_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            key_s1_q <= key;
            key_s2_q <= key_s1_q;
            key_s3_q <= key_s2_q;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            led_q    <= led_d;
            irq_q    <= irq_d;
        end
    end

    // Instruction fetch. A fetch beyond the ROM returns a NOP.
    always_comb begin
        out_rom = NOP;
        if ({1'b0, addr_rom} < IM_BYTES) out_rom = rom_q[addr_rom[IM_AW+1:2]];
    end

endmodule
